// File: rtl/utc_pkg.sv
// Shared definitions for the UTC converter scheduler.
// Holds the FSM state encoding, the calendar field widths, the weekday
// encoding (0 = Sunday) and the packed record of one converted timestamp.
package utc_pkg;

  localparam int YEAR_W  = 14;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;
  localparam int WDAY_W  = 3;
  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SUNDAY    = 3'd0,
    MONDAY    = 3'd1,
    TUESDAY   = 3'd2,
    WEDNESDAY = 3'd3,
    THURSDAY  = 3'd4,
    FRIDAY    = 3'd5,
    SATURDAY  = 3'd6
  } weekday_t;

  // One calendar result, most significant field first.
  typedef struct packed {
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
    logic [WDAY_W-1:0]  weekday;
    logic [HOUR_W-1:0]  hour;
    logic [MIN_W-1:0]   minute;
    logic [SEC_W-1:0]   second;
  } utc_fields_t;

endpackage

// File: rtl/utc_conv_scheduler_if.sv
// Requester-side bus of the UTC converter scheduler.
// master: the requesters (drive req0/req1 and time0/time1, see done/res/busy).
// slave : the scheduler (samples requests, returns done pulses and results).
interface utc_conv_scheduler_if;
  import utc_pkg::*;

  logic               req0;
  logic [63:0]        time0;
  logic               req1;
  logic [63:0]        time1;
  logic               done0;
  logic               done1;
  logic [YEAR_W-1:0]  res_year;
  logic [MONTH_W-1:0] res_month;
  logic [DAY_W-1:0]   res_day;
  logic [WDAY_W-1:0]  res_weekday;
  logic [HOUR_W-1:0]  res_hour;
  logic [MIN_W-1:0]   res_minute;
  logic [SEC_W-1:0]   res_second;
  logic               busy;

  modport master (
    output req0, time0, req1, time1,
    input  done0, done1, busy,
    input  res_year, res_month, res_day, res_weekday, res_hour, res_minute, res_second
  );

  modport slave (
    input  req0, time0, req1, time1,
    output done0, done1, busy,
    output res_year, res_month, res_day, res_weekday, res_hour, res_minute, res_second
  );

endinterface

// File: rtl/utc_conv_scheduler_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst (sync, active-high); req[1:0] request levels; en allows the
// last_grant register to advance; any_req flags a pending request; winner is
// the index chosen this cycle (combinational from req and last_grant).
// On a tie the requester that did not win last time is chosen; last_grant
// resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       any_req,
  output logic       winner
);

  logic last_grant;

  // Winner selection from the current requests and the previous grant.
  always_comb begin
    any_req = req[0] | req[1];
    winner  = 1'b0;
    if (req[0] && req[1]) begin
      winner = ~last_grant;
    end else if (req[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

  // Remember who won, only when a grant is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en && any_req) begin
      last_grant <= winner;
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/utc_conv_scheduler.sv
// Time-shares one unix64_to_UTC converter between two requesters.
// Ports: clk, rst (sync, active-high); bus (slave side: req/time in,
// done/res/busy out); conv_unix_time drives the converter input; conv_* are
// the converter's calendar outputs.
// The converter has no handshake, so the granted time is held on
// conv_unix_time for CONV_LATENCY cycles before the outputs are captured.
// All outputs are registered; req/time only reach them through flops.
module utc_conv_scheduler
  import utc_pkg::*;
#(
  parameter int CONV_LATENCY = 64
) (
  input  logic               clk,
  input  logic               rst,
  utc_conv_scheduler_if.slave bus,
  output logic [63:0]        conv_unix_time,
  input  logic [YEAR_W-1:0]  conv_year,
  input  logic [MONTH_W-1:0] conv_month,
  input  logic [DAY_W-1:0]   conv_day,
  input  logic [WDAY_W-1:0]  conv_weekday,
  input  logic [HOUR_W-1:0]  conv_hour,
  input  logic [MIN_W-1:0]   conv_minute,
  input  logic [SEC_W-1:0]   conv_second
);

  localparam int CNT_W = $clog2(CONV_LATENCY + 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             gnt;
  logic             grant_en;
  logic             any_req;
  logic             winner;

  // Grants are only issued while idle.
  assign grant_en = (state == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.req1, bus.req0}),
    .en      (grant_en),
    .any_req (any_req),
    .winner  (winner)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (cnt == {CNT_W{1'b0}}) begin
          next_state = CAPTURE;
        end else begin
          next_state = WAIT;
        end
      end
      CAPTURE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant latch, converter drive and settle counter.
  // conv_unix_time is deliberately left holding the last value after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_unix_time <= 64'd0;
      gnt            <= 1'b0;
      cnt            <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt            <= winner;
            conv_unix_time <= winner ? bus.time1 : bus.time0;
          end
        end
        LOAD: begin
          cnt <= CNT_W'(CONV_LATENCY - 1);
        end
        WAIT: begin
          if (cnt != {CNT_W{1'b0}}) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CAPTURE: begin
          cnt <= cnt;
        end
        default: begin
          cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Result capture; held until the next conversion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res_year    <= {YEAR_W{1'b0}};
      bus.res_month   <= {MONTH_W{1'b0}};
      bus.res_day     <= {DAY_W{1'b0}};
      bus.res_weekday <= {WDAY_W{1'b0}};
      bus.res_hour    <= {HOUR_W{1'b0}};
      bus.res_minute  <= {MIN_W{1'b0}};
      bus.res_second  <= {SEC_W{1'b0}};
    end else if (state == CAPTURE) begin
      bus.res_year    <= conv_year;
      bus.res_month   <= conv_month;
      bus.res_day     <= conv_day;
      bus.res_weekday <= conv_weekday;
      bus.res_hour    <= conv_hour;
      bus.res_minute  <= conv_minute;
      bus.res_second  <= conv_second;
    end
  end

  // Done pulses land in the first IDLE cycle, together with the new result.
  // busy is registered from next_state so it matches "state != IDLE".
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.done0 <= 1'b0;
      bus.done1 <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      bus.done0 <= (state == CAPTURE) && !gnt;
      bus.done1 <= (state == CAPTURE) && gnt;
      bus.busy  <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_utc_conv_scheduler.sv
// Self-checking bench for utc_conv_scheduler with a behavioural converter
// stand-in (outputs are garbage until its input has been stable a while).
module tb_utc_conv_scheduler;
  import utc_pkg::*;

  localparam int CONV_LATENCY = 64;
  localparam int LAT_EDGES    = CONV_LATENCY + 3; // request edge .. done sample, inclusive
  localparam int MODEL_CNT    = CONV_LATENCY + 2; // edges after grant until done
  localparam int SETTLE       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  utc_conv_scheduler_if bus();

  logic [63:0]        conv_unix_time;
  logic [YEAR_W-1:0]  conv_year;
  logic [MONTH_W-1:0] conv_month;
  logic [DAY_W-1:0]   conv_day;
  logic [WDAY_W-1:0]  conv_weekday;
  logic [HOUR_W-1:0]  conv_hour;
  logic [MIN_W-1:0]   conv_minute;
  logic [SEC_W-1:0]   conv_second;

  utc_conv_scheduler #(.CONV_LATENCY(CONV_LATENCY)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .conv_unix_time (conv_unix_time),
    .conv_year      (conv_year),
    .conv_month     (conv_month),
    .conv_day       (conv_day),
    .conv_weekday   (conv_weekday),
    .conv_hour      (conv_hour),
    .conv_minute    (conv_minute),
    .conv_second    (conv_second)
  );

  // Calendar from unix seconds (days-from-civil inverse, proleptic Gregorian).
  function automatic utc_fields_t to_utc(input logic [63:0] t);
    utc_fields_t r;
    longint days, sod, z, era, doe, yoe, y, doy, mp, d, m;
    days = longint'(t / 64'd86400);
    sod  = longint'(t % 64'd86400);
    z    = days + 719468;
    era  = z / 146097;
    doe  = z - era * 146097;
    yoe  = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
    y    = yoe + era * 400;
    doy  = doe - (365 * yoe + yoe / 4 - yoe / 100);
    mp   = (5 * doy + 2) / 153;
    d    = doy - (153 * mp + 2) / 5 + 1;
    m    = (mp < 10) ? mp + 3 : mp - 9;
    if (m <= 2) y = y + 1;
    r.year    = 14'(y);
    r.month   = 4'(m);
    r.day     = 5'(d);
    r.weekday = 3'((days + 4) % 7);
    r.hour    = 5'(sod / 3600);
    r.minute  = 6'((sod % 3600) / 60);
    r.second  = 6'(sod % 60);
    return r;
  endfunction

  function automatic utc_fields_t mk(input int y, input int mo, input int d, input int wd,
                                     input int h, input int mi, input int s);
    utc_fields_t r;
    r.year = 14'(y); r.month = 4'(mo); r.day = 5'(d); r.weekday = 3'(wd);
    r.hour = 5'(h); r.minute = 6'(mi); r.second = 6'(s);
    return r;
  endfunction

  // Converter stand-in: tracks how long its input has been stable.
  logic [63:0] seen_time = 64'd0;
  int          stable    = 0;
  utc_fields_t conv_now;
  always @(posedge clk) begin
    if (conv_unix_time != seen_time) begin
      seen_time <= conv_unix_time;
      stable    <= 0;
    end else if (stable < 1000) begin
      stable <= stable + 1;
    end
  end
  always_comb conv_now = (stable >= SETTLE) ? to_utc(conv_unix_time) : '1;
  assign conv_year    = conv_now.year;
  assign conv_month   = conv_now.month;
  assign conv_day     = conv_now.day;
  assign conv_weekday = conv_now.weekday;
  assign conv_hour    = conv_now.hour;
  assign conv_minute  = conv_now.minute;
  assign conv_second  = conv_now.second;

  utc_fields_t res_now;
  assign res_now = {bus.res_year, bus.res_month, bus.res_day, bus.res_weekday,
                    bus.res_hour, bus.res_minute, bus.res_second};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a done pulse; which = 0/1, 2 if both, -1 on timeout.
  task automatic wait_done(output int which, output int edges, output int busy_low);
    which = -1; edges = 0; busy_low = 0;
    for (int i = 0; i < LAT_EDGES + 20; i++) begin
      tick();
      edges++;
      if (!bus.busy) busy_low++;
      if (bus.done0 || bus.done1) begin
        which = (bus.done0 && bus.done1) ? 2 : (bus.done1 ? 1 : 0);
        break;
      end
    end
  endtask

  task automatic run_single(input bit rq, input logic [63:0] t, output int which, output int edges);
    int bl;
    if (rq) begin bus.req1 = 1'b1; bus.time1 = t; end
    else    begin bus.req0 = 1'b1; bus.time0 = t; end
    wait_done(which, edges, bl);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  typedef struct {
    bit          rq;
    logic [63:0] t;
    utc_fields_t exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int which, edges, bl;
    bit flag_a, flag_b;
    utc_fields_t held;
    bit r0, r1, m_busy, m_gnt, m_last, e0, e1;
    int m_cnt;
    logic [63:0] t0, t1, m_time;
    utc_fields_t m_res;

    // 1709220330 s is 2024-02-29 15:25:30 UTC.
    vecs[0] = '{1'b0, 64'd1682944496, mk(2023, 5, 1, 1, 12, 34, 56)};
    vecs[1] = '{1'b1, 64'd946684800,  mk(2000, 1, 1, 6, 0, 0, 0)};
    vecs[2] = '{1'b0, 64'd1709220330, mk(2024, 2, 29, 4, 15, 25, 30)};
    vecs[3] = '{1'b1, 64'd2147483647, mk(2038, 1, 19, 2, 3, 14, 7)};
    vecs[4] = '{1'b0, 64'd951868800,  mk(2000, 3, 1, 3, 0, 0, 0)};
    vecs[5] = '{1'b0, 64'd951868800,  mk(2000, 3, 1, 3, 0, 0, 0)};

    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.time0 = 64'd0; bus.time1 = 64'd0;
    do_reset();
    check("reset_conv", conv_unix_time, 64'd0);
    check("reset_res", 64'(res_now), 64'd0);
    check("reset_done", {62'd0, bus.done1, bus.done0}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);

    // Table: single requests, latency and result per vector.
    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i].rq, vecs[i].t, which, edges);
      check($sformatf("vec%0d_which", i), 64'(which), 64'(vecs[i].rq));
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'(LAT_EDGES));
      check($sformatf("vec%0d_res", i), 64'(res_now), 64'(vecs[i].exp));
      check($sformatf("vec%0d_conv", i), conv_unix_time, vecs[i].t);
      tick();
    end

    // Stale result hold for 200 idle cycles.
    held = res_now;
    flag_a = 1'b0; flag_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (res_now !== held) flag_a = 1'b1;
      if (bus.busy !== 1'b0 || bus.done0 || bus.done1) flag_b = 1'b1;
    end
    check("hold_res_changed", {63'd0, flag_a}, 64'd0);
    check("hold_busy_or_done", {63'd0, flag_b}, 64'd0);

    // Simultaneous requests from reset: 0 first, then 1 in the next IDLE.
    do_reset();
    bus.req0 = 1'b1; bus.time0 = 64'd946684800;
    bus.req1 = 1'b1; bus.time1 = 64'd1709220330;
    wait_done(which, edges, bl);
    bus.req0 = 1'b0;
    check("tie_first_which", 64'(which), 64'd0);
    check("tie_first_res", 64'(res_now), 64'(mk(2000, 1, 1, 6, 0, 0, 0)));
    wait_done(which, edges, bl);
    bus.req1 = 1'b0;
    check("tie_second_which", 64'(which), 64'd1);
    check("tie_second_latency", 64'(edges), 64'(LAT_EDGES));
    check("tie_second_res", 64'(res_now), 64'(mk(2024, 2, 29, 4, 15, 25, 30)));

    // Fairness: both held for 6 conversions.
    do_reset();
    bus.req0 = 1'b1; bus.time0 = 64'd1682944496;
    bus.req1 = 1'b1; bus.time1 = 64'd951868800;
    for (int k = 0; k < 6; k++) begin
      wait_done(which, edges, bl);
      check($sformatf("fair%0d_which", k), 64'(which), 64'(k % 2));
      check($sformatf("fair%0d_busy_low", k), 64'(bl), 64'd1);
      check($sformatf("fair%0d_latency", k), 64'(edges), 64'(LAT_EDGES));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // Time change after grant is ignored.
    do_reset();
    bus.req0 = 1'b1; bus.time0 = 64'd0;
    tick();
    repeat (5) tick();
    bus.time0 = 64'd2147483647;
    flag_a = 1'b0; which = -1;
    for (int i = 0; i < LAT_EDGES + 20; i++) begin
      tick();
      if (conv_unix_time !== 64'd0) flag_a = 1'b1;
      if (bus.done0 || bus.done1) begin which = bus.done1 ? 1 : 0; break; end
    end
    bus.req0 = 1'b0;
    check("late_change_conv", {63'd0, flag_a}, 64'd0);
    check("late_change_which", 64'(which), 64'd0);
    check("late_change_res", 64'(res_now), 64'(mk(1970, 1, 1, 4, 0, 0, 0)));

    // Reset during WAIT aborts without a done pulse.
    run_single(1'b0, 64'd1682944496, which, edges);
    tick();
    bus.req0 = 1'b1; bus.time0 = 64'd2147483647;
    repeat (32) tick();
    rst = 1'b1; bus.req0 = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_conv", conv_unix_time, 64'd0);
    check("abort_res", 64'(res_now), 64'd0);
    check("abort_done_busy", {61'd0, bus.busy, bus.done1, bus.done0}, 64'd0);
    flag_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.done0 || bus.done1 || bus.busy) flag_a = 1'b1;
    end
    check("abort_no_done", {63'd0, flag_a}, 64'd0);
    run_single(1'b1, 64'd946684800, which, edges);
    check("abort_fresh_which", 64'(which), 64'd1);
    check("abort_fresh_latency", 64'(edges), 64'(LAT_EDGES));
    check("abort_fresh_res", 64'(res_now), 64'(mk(2000, 1, 1, 6, 0, 0, 0)));

    // Randomised traffic against a cycle-count reference model.
    do_reset();
    r0 = 1'b0; r1 = 1'b0; t0 = 64'd0; t1 = 64'd0;
    m_busy = 1'b0; m_gnt = 1'b0; m_last = 1'b1; m_cnt = 0; m_time = 64'd0;
    m_res = '0; e0 = 1'b0; e1 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (r0 && e0) begin
        r0 = ($urandom_range(0, 3) == 0);
        t0 = {$urandom_range(0, 3), $urandom()};
      end else if (r0) begin
        if ($urandom_range(0, 7) == 0) t0 = {$urandom_range(0, 3), $urandom()};
      end else if ($urandom_range(0, 3) == 0) begin
        r0 = 1'b1; t0 = {$urandom_range(0, 3), $urandom()};
      end
      if (r1 && e1) begin
        r1 = ($urandom_range(0, 3) == 0);
        t1 = {$urandom_range(0, 3), $urandom()};
      end else if (r1) begin
        if ($urandom_range(0, 7) == 0) t1 = {$urandom_range(0, 3), $urandom()};
      end else if ($urandom_range(0, 3) == 0) begin
        r1 = 1'b1; t1 = {$urandom_range(0, 3), $urandom()};
      end
      bus.req0 = r0; bus.time0 = t0; bus.req1 = r1; bus.time1 = t1;
      @(posedge clk);
      e0 = 1'b0; e1 = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_res  = to_utc(m_time);
          if (m_gnt) e1 = 1'b1; else e0 = 1'b1;
        end
      end else if (r0 || r1) begin
        m_gnt  = (r0 && r1) ? ~m_last : r1;
        m_last = m_gnt;
        m_time = m_gnt ? t1 : t0;
        m_busy = 1'b1;
        m_cnt  = MODEL_CNT;
      end
      #1;
      check("rnd_done0", {63'd0, bus.done0}, {63'd0, e0});
      check("rnd_done1", {63'd0, bus.done1}, {63'd0, e1});
      check("rnd_busy", {63'd0, bus.busy}, {63'd0, m_busy});
      check("rnd_conv", conv_unix_time, m_time);
      check("rnd_res", 64'(res_now), 64'(m_res));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
